// File: rtl/timer_device.sv
// Programmable interval timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload countdown, masked interrupt request.
module timer_device #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam int unsigned CTRL_WIDTH = 4;
  localparam int unsigned EN_BIT     = 0;
  localparam int unsigned IM_BIT     = 3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_e;

  state_e                state_q,    state_d;
  logic [CTRL_WIDTH-1:0] ctrl_q,     ctrl_d;
  logic [CNT_WIDTH-1:0]  preset_q,   preset_d;
  logic [CNT_WIDTH-1:0]  count_q,    count_d;
  logic                  irq_flag_q, irq_flag_d;
  logic                  irq_q,      irq_d;

  // Next-state: timer sequencing first, then CPU writes override CTRL/PRESET.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[EN_BIT]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[EN_BIT]) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end else begin
          count_d = count_q - CNT_WIDTH'(1);
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CTRL write replaces whatever the sequencer did to CTRL and drops the flag.
    if (We) begin
      if (Addr == ADDR_CTRL) begin
        ctrl_d     = DIn[CTRL_WIDTH-1:0];
        irq_flag_d = 1'b0;
      end else if (Addr == ADDR_PRESET) begin
        preset_d = DIn[CNT_WIDTH-1:0];
      end
    end

    irq_d = irq_flag_d & ctrl_d[IM_BIT];
  end

  // State and register bank, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    DOut = 32'd0;
    unique case (Addr)
      ADDR_CTRL:   DOut = 32'(ctrl_q);
      ADDR_PRESET: DOut = 32'(preset_q);
      ADDR_COUNT:  DOut = 32'(count_q);
      default:     DOut = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Programmable interval timer on the processor's external bus, downstream of the CPU's Pr* bus via the system bridge.
- The bridge decodes the timer's address window and drives word address, write enable and write data here.
- Read data returns to the CPU's PrRD path.
- IRQ drives one bit of the CPU's HWInt[7:2] interrupt vector.

Parameters:
- CNT_WIDTH, 32, width of PRESET and COUNT registers (1..32); read data is zero-extended to 32 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Addr  input  2  word select within the timer window: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- We  input  1  write enable, already qualified by the bridge's address decode.
- DIn  input  32  write data.
- DOut  output  32  combinational read data for Addr.
- IRQ  output  1  interrupt request to HWInt.

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask).
  - PRESET[CNT_WIDTH-1:0].
  - COUNT[CNT_WIDTH-1:0] is read-only.
  - Internal irq_flag; FSM state.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Consequently DOut=0 for Addr 0/2/3, IRQ=0.
- Reads (combinational, no latency):
  - Addr0 → {28'b0,CTRL}
  - Addr1 → PRESET
  - Addr2 → COUNT
  - Addr3 → 0
- Writes, on a clock edge with We=1:
  - Addr0: CTRL<=DIn[3:0], DIn[31:4] ignored; also clears irq_flag.
  - Addr1: PRESET<=DIn[CNT_WIDTH-1:0].
  - Addr2 and Addr3: ignored, no side effect.
- IRQ = irq_flag & CTRL.IM.
- FSM, one transition per edge:
  - IDLE: if Enable → LOAD; else stay, COUNT holds.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - if !Enable → IDLE (COUNT frozen);
    - else if COUNT==0 → INT, irq_flag<=1;
    - else COUNT<=COUNT-1.
  - INT:
    - Mode 00 (one-shot): Enable<=0 → IDLE; irq_flag stays 1 until a CTRL write or reset.
    - Mode 01 (auto-reload): irq_flag<=0 → LOAD; IRQ is a single-cycle pulse.
    - Modes 10/11 behave as 00.
- Latency:
  - CTRL write enabling with PRESET=N at edge 0 → IRQ rises after edge N+3.
  - Mode 01 period is N+3 cycles.
  - PRESET=0: IRQ after edge 3.
- Simultaneous events:
  - A CPU write to CTRL on the same edge the FSM clears Enable in INT: CPU value wins, irq_flag cleared. The FSM still leaves INT per the mode rule.
  - A CTRL write that clears Enable in LOAD: LOAD completes, then CNT sees !Enable → IDLE.
  - A PRESET write during CNT does not affect the running count; it is used at the next LOAD.
  - A write setting Enable while in IDLE goes to LOAD on the following edge.
- COUNT never wraps: decrement only while COUNT>0.
- Reset asserted mid-count aborts immediately; after release the timer stays idle until CTRL is written.

Test Plan:
- Reset: reset=0 for 2 cycles with random We/DIn → DOut=0 at Addr0..3, IRQ=0; Addr1 reads 0 after release.
- One-shot: write PRESET=5, then CTRL=4'b1001 at edge 0 → COUNT reads 5,4,3,2,1,0; IRQ=1 from after edge 8 onward; CTRL reads 4'b1000 (Enable cleared). A CTRL write of 0 clears IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 → IRQ 1-cycle pulses every 6 cycles, first after edge 6; Enable stays 1.
- Masking: one-shot with IM=0, PRESET=2 → irq_flag set but IRQ stays 0. A later CTRL write of 4'b1000 does not raise IRQ because the flag was cleared by that write.
- Pause/edge cases: during CNT with COUNT=10, write CTRL Enable=0 → COUNT frozen at 9 for 5 cycles. PRESET write of 7 mid-count does not alter COUNT. Addr2/Addr3 writes change nothing. PRESET=0 gives IRQ after edge 3.
- Async reset mid-operation: assert reset between edges while COUNT=4 → COUNT, CTRL, IRQ go to 0 immediately without a clock edge; no counting resumes after release.
